// File: rtl/mem_access.sv
// mem_access: memory-access stage behind the EX/MEM register.
// Issues one load/store at a time over a req/ack data-memory port, stalls
// upstream while it is outstanding, extends load data and registers the
// MEM/WB writeback slot.
// Optional feature macro: MEM_ACCESS_TIMEOUT_EN (ack-wait timeout, bus_err_o).
// Handshake: dmem_req_o rises on entry to WAIT and stays high with addr/we/be/
// wdata frozen until a cycle in which dmem_ack_i is high; that cycle completes
// the access. dmem_ack_i is ignored outside WAIT.
module mem_access #(
  parameter int WordSize      = 32,
  parameter int TimeoutCycles = 16
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                in_valid_i,
  input  logic [4:0]          rdn_i,
  input  logic [WordSize-1:0] alu_out_i,
  input  logic [WordSize-1:0] mem_data_i,
  input  logic                mem_read_i,
  input  logic                mem_write_i,
  input  logic [2:0]          funct3_i,
  output logic                stall_o,
  output logic                dmem_req_o,
  output logic                dmem_we_o,
  output logic [WordSize-1:0] dmem_addr_o,
  output logic [3:0]          dmem_be_o,
  output logic [WordSize-1:0] dmem_wdata_o,
  input  logic [WordSize-1:0] dmem_rdata_i,
  input  logic                dmem_ack_i,
  output logic                wb_valid_o,
  output logic [4:0]          wb_rdn_o,
  output logic [WordSize-1:0] wb_data_o,
  output logic                misalign_o,
  output logic                bus_err_o,
  output logic                dbg_state_o
);

  typedef enum logic {ST_IDLE = 1'b0, ST_WAIT = 1'b1} state_t;
  typedef enum logic [1:0] {SZ_B = 2'd0, SZ_H = 2'd1, SZ_W = 2'd2} size_t;

  state_t                state_q;
  logic                  req_q, we_q;
  logic [WordSize-1:0]   addr_q, wdata_q;
  logic [3:0]            be_q;
  logic [4:0]            rdn_q;
  size_t                 size_q;
  logic                  uns_q;
  logic [1:0]            lo_q;
  logic                  wb_valid_q, misalign_q;
  logic [4:0]            wb_rdn_q;
  logic [WordSize-1:0]   wb_data_q;

  logic                  mem_op, misaligned, timeout_hit;
  size_t                 size_d;
  logic                  uns_d;
  logic [3:0]            be_d;
  logic [WordSize-1:0]   wdata_d, shifted, ld_data_d;

  // Decode access size/sign; unsupported encodings behave as a word access.
  always_comb begin
    size_d = SZ_W;
    uns_d  = 1'b0;
    case (funct3_i)
      3'b000: size_d = SZ_B;
      3'b001: size_d = SZ_H;
      3'b100: begin size_d = SZ_B; uns_d = 1'b1; end
      3'b101: begin size_d = SZ_H; uns_d = 1'b1; end
      default: size_d = SZ_W;
    endcase
  end

  assign mem_op = in_valid_i && (mem_read_i || mem_write_i);

  // Alignment check, byte enables and lane-replicated store data for the incoming op.
  always_comb begin
    misaligned = 1'b0;
    be_d       = 4'b1111;
    wdata_d    = mem_data_i;
    case (size_d)
      SZ_B: begin
        be_d    = 4'b0001 << alu_out_i[1:0];
        wdata_d = {4{mem_data_i[7:0]}};
      end
      SZ_H: begin
        misaligned = alu_out_i[0];
        be_d       = 4'b0011 << alu_out_i[1:0];
        wdata_d    = {2{mem_data_i[15:0]}};
      end
      default: misaligned = (alu_out_i[1:0] != 2'b00);
    endcase
  end

  // Select the addressed lane from the returned word and extend it.
  assign shifted = dmem_rdata_i >> {lo_q, 3'b000};
  always_comb begin
    ld_data_d = shifted;
    case (size_q)
      SZ_B: ld_data_d = uns_q ? {{(WordSize-8){1'b0}}, shifted[7:0]}
                              : {{(WordSize-8){shifted[7]}}, shifted[7:0]};
      SZ_H: ld_data_d = uns_q ? {{(WordSize-16){1'b0}}, shifted[15:0]}
                              : {{(WordSize-16){shifted[15]}}, shifted[15:0]};
      default: ld_data_d = shifted;
    endcase
  end

`ifdef MEM_ACCESS_TIMEOUT_EN
  localparam int CntW = (TimeoutCycles > 1) ? $clog2(TimeoutCycles) : 1;
  logic [CntW-1:0] cnt_q;
  logic            bus_err_q;
  // An ack in the limit cycle takes priority over the timeout.
  assign timeout_hit = (state_q == ST_WAIT) && !dmem_ack_i &&
                       (cnt_q == CntW'(TimeoutCycles - 1));
  assign bus_err_o   = bus_err_q;
`else
  assign timeout_hit = 1'b0;
  assign bus_err_o   = 1'b0;
`endif

  // Stall while a new aligned access is being launched or one is still waiting.
  assign stall_o = (state_q == ST_IDLE) ? (mem_op && !misaligned)
                                        : (!dmem_ack_i && !timeout_hit);

  // FSM with registered request and writeback outputs.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= ST_IDLE;
      req_q      <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      be_q       <= '0;
      rdn_q      <= '0;
      size_q     <= SZ_W;
      uns_q      <= 1'b0;
      lo_q       <= '0;
      wb_valid_q <= 1'b0;
      wb_rdn_q   <= '0;
      wb_data_q  <= '0;
      misalign_q <= 1'b0;
`ifdef MEM_ACCESS_TIMEOUT_EN
      cnt_q      <= '0;
      bus_err_q  <= 1'b0;
`endif
    end else begin
      wb_valid_q <= 1'b0;
      misalign_q <= 1'b0;
`ifdef MEM_ACCESS_TIMEOUT_EN
      bus_err_q  <= 1'b0;
`endif
      case (state_q)
        ST_IDLE: begin
          if (mem_op) begin
            if (misaligned) begin
              misalign_q <= 1'b1;
            end else begin
              state_q <= ST_WAIT;
              req_q   <= 1'b1;
              we_q    <= mem_write_i;
              addr_q  <= {alu_out_i[WordSize-1:2], 2'b00};
              be_q    <= be_d;
              wdata_q <= wdata_d;
              rdn_q   <= rdn_i;
              size_q  <= size_d;
              uns_q   <= uns_d;
              lo_q    <= alu_out_i[1:0];
`ifdef MEM_ACCESS_TIMEOUT_EN
              cnt_q   <= '0;
`endif
            end
          end else begin
            wb_valid_q <= in_valid_i;
            wb_rdn_q   <= rdn_i;
            wb_data_q  <= alu_out_i;
          end
        end
        ST_WAIT: begin
          if (dmem_ack_i) begin
            state_q    <= ST_IDLE;
            req_q      <= 1'b0;
            wb_valid_q <= !we_q;
            wb_rdn_q   <= rdn_q;
            wb_data_q  <= ld_data_d;
          end else if (timeout_hit) begin
            state_q <= ST_IDLE;
            req_q   <= 1'b0;
`ifdef MEM_ACCESS_TIMEOUT_EN
            bus_err_q <= 1'b1;
`endif
          end else begin
`ifdef MEM_ACCESS_TIMEOUT_EN
            cnt_q <= cnt_q + 1'b1;
`endif
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign dmem_req_o   = req_q;
  assign dmem_we_o    = we_q;
  assign dmem_addr_o  = addr_q;
  assign dmem_be_o    = be_q;
  assign dmem_wdata_o = wdata_q;
  assign wb_valid_o   = wb_valid_q;
  assign wb_rdn_o     = wb_rdn_q;
  assign wb_data_o    = wb_data_q;
  assign misalign_o   = misalign_q;
  assign dbg_state_o  = state_q;

endmodule

// File: tb/tb_mem_access.sv
// tb_mem_access: randomized and directed bench for mem_access against a
// transaction-level reference model (size/sign rules computed arithmetically).
module tb_mem_access;

  logic        clk, rst;
  logic        in_valid, mem_read, mem_write, dmem_ack;
  logic [4:0]  rdn;
  logic [31:0] alu_out, mem_data, dmem_rdata;
  logic [2:0]  funct3;
  logic        stall, dmem_req, dmem_we, wb_valid, misalign, bus_err, dbg_state;
  logic [31:0] dmem_addr, dmem_wdata, wb_data;
  logic [3:0]  dmem_be;
  logic [4:0]  wb_rdn;

  int n_vec = 0;
  int n_err = 0;
  logic [31:0] exp_q[$];

  mem_access #(.WordSize(32), .TimeoutCycles(4)) dut (
    .clk_i(clk), .rst_i(rst), .in_valid_i(in_valid), .rdn_i(rdn),
    .alu_out_i(alu_out), .mem_data_i(mem_data), .mem_read_i(mem_read),
    .mem_write_i(mem_write), .funct3_i(funct3), .stall_o(stall),
    .dmem_req_o(dmem_req), .dmem_we_o(dmem_we), .dmem_addr_o(dmem_addr),
    .dmem_be_o(dmem_be), .dmem_wdata_o(dmem_wdata), .dmem_rdata_i(dmem_rdata),
    .dmem_ack_i(dmem_ack), .wb_valid_o(wb_valid), .wb_rdn_o(wb_rdn),
    .wb_data_o(wb_data), .misalign_o(misalign), .bus_err_o(bus_err),
    .dbg_state_o(dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Reference model pieces, derived from the size/sign rules.
  function automatic int size_of(input logic [2:0] f3);
    if (f3 == 3'd0 || f3 == 3'd4) return 1;
    if (f3 == 3'd1 || f3 == 3'd5) return 2;
    return 4;
  endfunction

  function automatic logic [3:0] model_be(input int n, input logic [31:0] a);
    int v;
    if (n == 4) return 4'hf;
    v = ((1 << n) - 1) << (a % 4);
    return v[3:0];
  endfunction

  function automatic logic [31:0] model_wdata(input int n, input logic [31:0] d);
    if (n == 1) return (d & 32'hff) * 32'h0101_0101;
    if (n == 2) return (d & 32'hffff) * 32'h0001_0001;
    return d;
  endfunction

  function automatic logic [31:0] model_load(input int n, input bit sgn,
                                             input logic [31:0] a, input logic [31:0] rd);
    longint mask, v;
    if (n == 4) return rd;
    mask = (64'd1 << (8 * n)) - 1;
    v = (longint'(rd) >> (8 * (a % 4))) & mask;
    if (sgn && ((v >> (8 * n - 1)) & 1) == 1) v = v | ~mask;
    return v[31:0];
  endfunction

  task automatic set_idle();
    in_valid = 0; mem_read = 0; mem_write = 0; rdn = 0;
    alu_out = 0; mem_data = 0; funct3 = 0; dmem_ack = 0; dmem_rdata = 0;
  endtask

  // Driver: applies one instruction starting at a negedge and returns at the
  // negedge where its writeback/misalign result is visible (already checked).
  task automatic do_op(input bit v, input logic [4:0] rd, input logic [31:0] a,
                       input logic [31:0] sd, input bit rdop, input bit wrop,
                       input logic [2:0] f3, input int dly, input logic [31:0] rdata);
    bit is_mem, is_st, sgn, mis;
    int n;
    logic [31:0] exp_d;
    is_mem = v && (rdop || wrop);
    is_st  = wrop;
    n      = size_of(f3);
    sgn    = (f3 == 3'd0 || f3 == 3'd1);
    mis    = (a % n) != 0;
    in_valid = v; rdn = rd; alu_out = a; mem_data = sd;
    mem_read = rdop; mem_write = wrop; funct3 = f3; dmem_ack = 0;
    dmem_rdata = $urandom;
    #1;
    if (!is_mem) begin
      check("pass_stall", stall, 0);
      check("pass_req", dmem_req, 0);
      exp_q.push_back(a);
      @(negedge clk);
      check("pass_wb_valid", wb_valid, v);
      exp_d = exp_q.pop_front();
      if (v) begin
        check("pass_wb_rdn", wb_rdn, rd);
        check("pass_wb_data", wb_data, exp_d);
      end
      check("pass_misalign", misalign, 0);
    end else if (mis) begin
      check("mis_stall", stall, 0);
      check("mis_req", dmem_req, 0);
      @(negedge clk);
      check("mis_flag", misalign, 1);
      check("mis_wb_valid", wb_valid, 0);
      check("mis_req_after", dmem_req, 0);
    end else begin
      check("issue_stall", stall, 1);
      check("issue_req", dmem_req, 0);
      check("issue_state", dbg_state, 0);
      if (!is_st) exp_q.push_back(model_load(n, sgn, a, rdata));
      @(negedge clk);
      for (int k = 0; k <= dly; k++) begin
        dmem_rdata = (k == dly) ? rdata : $urandom;
        dmem_ack   = (k == dly);
        #1;
        check("wait_req", dmem_req, 1);
        check("wait_addr", dmem_addr, a & 32'hffff_fffc);
        check("wait_be", dmem_be, model_be(n, a));
        check("wait_we", dmem_we, is_st);
        if (is_st) check("wait_wdata", dmem_wdata, model_wdata(n, sd));
        check("wait_stall", stall, k != dly);
        @(negedge clk);
      end
      dmem_ack = 0;
      check("done_wb_valid", wb_valid, !is_st);
      check("done_req", dmem_req, 0);
      if (!is_st) begin
        exp_d = exp_q.pop_front();
        check("done_wb_rdn", wb_rdn, rd);
        check("done_wb_data", wb_data, exp_d);
      end
    end
    check("no_bus_err", bus_err, 0);
  endtask

  initial begin
    logic [2:0]  f3_tab [0:7];
    logic [31:0] a, r;
    int kind;
    f3_tab = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5, 3'd3, 3'd6, 3'd7};
    set_idle();
    rst = 1;
    repeat (3) @(negedge clk);
    check("rst_req", dmem_req, 0);
    check("rst_wb_valid", wb_valid, 0);
    check("rst_wb_data", wb_data, 0);
    check("rst_state", dbg_state, 0);
    rst = 0;
    @(negedge clk);

    // Directed cases.
    do_op(1, 5'd5, 32'h1234, 0, 0, 0, 3'd0, 0, 0);
    do_op(1, 5'd7, 32'h103, 0, 1, 0, 3'd0, 3, 32'h80FF_FF00);
    do_op(1, 5'd3, 32'h202, 32'hAAAA_BEEF, 0, 1, 3'd1, 0, 0);
    do_op(1, 5'd9, 32'h101, 0, 1, 0, 3'd2, 0, 0);
    do_op(1, 5'd2, 32'h42, 0, 1, 0, 3'd5, 1, 32'h8001_7FFF);
    do_op(1, 5'd4, 32'h41, 0, 1, 0, 3'd4, 0, 32'h1234_F0AB);
    do_op(1, 5'd0, 32'h80, 0, 1, 0, 3'd2, 2, 32'hDEAD_BEEF);
    do_op(1, 5'd6, 32'h84, 32'h1122_3344, 1, 1, 3'd0, 0, 0);
    do_op(1, 5'd8, 32'h88, 32'h5566_7788, 0, 1, 3'd3, 1, 0);
    do_op(1, 5'd8, 32'h8A, 32'h5566_7788, 0, 1, 3'd7, 0, 0);
    do_op(0, 5'd1, 32'h90, 0, 1, 0, 3'd2, 0, 0);

    // Reset while waiting for an ack; the late ack must be ignored.
    in_valid = 1; rdn = 5'd4; alu_out = 32'h40; mem_read = 1; funct3 = 3'd2;
    @(negedge clk);
    #1 check("rstw_req_before", dmem_req, 1);
    rst = 1; set_idle();
    @(negedge clk);
    check("rstw_req", dmem_req, 0);
    check("rstw_state", dbg_state, 0);
    check("rstw_stall", stall, 0);
    check("rstw_addr", dmem_addr, 0);
    check("rstw_be", dmem_be, 0);
    check("rstw_we", dmem_we, 0);
    check("rstw_wdata", dmem_wdata, 0);
    check("rstw_wb_rdn", wb_rdn, 0);
    check("rstw_misalign", misalign, 0);
    check("rstw_bus_err", bus_err, 0);
    rst = 0;
    @(negedge clk);
    dmem_ack = 1; dmem_rdata = 32'hFFFF_FFFF;
    #1 check("late_ack_stall", stall, 0);
    @(negedge clk);
    dmem_ack = 0;
    check("late_ack_req", dmem_req, 0);
    check("late_ack_wb_valid", wb_valid, 0);
    check("late_ack_state", dbg_state, 0);

`ifdef MEM_ACCESS_TIMEOUT_EN
    // No ack: four WAIT cycles, then drop request and pulse bus_err once.
    in_valid = 1; rdn = 5'd3; alu_out = 32'h60; mem_read = 1; funct3 = 3'd2;
    @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      #1;
      check("to_req", dmem_req, 1);
      check("to_stall", stall, k < 3);
      @(negedge clk);
    end
    set_idle();
    check("to_req_drop", dmem_req, 0);
    check("to_bus_err", bus_err, 1);
    check("to_wb_valid", wb_valid, 0);
    @(negedge clk);
    check("to_bus_err_pulse", bus_err, 0);
`else
    // Without the timeout the access waits as long as it takes.
    do_op(1, 5'd11, 32'h70, 0, 1, 0, 3'd1, 12, 32'h0000_8123);
`endif

    // Randomized mix of loads, stores, passthroughs and misaligned ops.
    for (int i = 0; i < 60; i++) begin
      kind = $urandom_range(0, 3);
      a = $urandom;
      r = $urandom;
      if ($urandom_range(0, 2) != 0) a[1:0] = 2'b00 | (2'($urandom_range(0, 1)) << 1);
      do_op($urandom_range(0, 7) != 0, 5'($urandom_range(0, 31)), a, $urandom,
            kind == 1 || kind == 3, kind == 2 || kind == 3,
            f3_tab[$urandom_range(0, 7)], $urandom_range(0, 3), r);
    end

    set_idle();
    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
